keypad_pin_collector: RTL

//  Upstream stage of the parking-gate controller. Collects 4 BCD keypad digits

---
 rtl/keypad_pin_collector_if.sv | 23 ++
 rtl/keypad_pin_collector.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/keypad_pin_collector_if.sv
// Keypad-side bundle of the PIN collector: key strobes in, submitted PIN and status out.
interface keypad_pin_collector_if;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        key_enter;
    logic        key_clear;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        key_error;
    logic        entry_timeout;

    modport master (
        output enable, key_valid, key_value, key_enter, key_clear,
        input  code, code_ack, digit_count, key_error, entry_timeout
    );

    modport slave (
        input  enable, key_valid, key_value, key_enter, key_clear,
        output code, code_ack, digit_count, key_error, entry_timeout
    );
endinterface

// File: rtl/keypad_pin_collector.sv
// Keypad PIN collector: gathers four BCD digits and hands the PIN to the
// gate controller as a code/code_ack level with a guaranteed low gap after it.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no vehicle; keys ignored
//  COLLECT | accepting digits, clear, enter; idle timeout armed when buffer non-empty
//  ACK     | code_ack high for ACK_CYCLES cycles; keys ignored
//  GAP     | one cycle with code_ack low before accepting a new entry
module keypad_pin_collector #(
    parameter int ACK_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    keypad_pin_collector_if.slave        kp
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ACK_W = $clog2(ACK_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ACK     = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       buf_q, buf_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       code_q, code_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [TMO_W-1:0]  idle_q, idle_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;

    logic              any_key;

    assign any_key = kp.key_valid | kp.key_enter | kp.key_clear;

    // Next-state and next-output computation for the whole collector.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        ack_d     = ack_q;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        idle_d    = idle_q;
        ack_cnt_d = ack_cnt_q;

        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (kp.enable) begin
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (!kp.enable) begin
                    // Vehicle left: abort wins over any key in the same cycle.
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end else if (any_key) begin
                    idle_d = TMO_LOAD;
                    if (kp.key_clear) begin
                        buf_d = '0;
                        cnt_d = '0;
                    end else if (kp.key_enter) begin
                        // A digit strobed together with enter is dropped on purpose.
                        if (cnt_q == 3'd4) begin
                            code_d    = buf_q;
                            ack_d     = 1'b1;
                            ack_cnt_d = ACK_LOAD;
                            state_d   = ACK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if ((kp.key_value <= 4'd9) && (cnt_q != 3'd4)) begin
                            buf_d = {buf_q[11:0], kp.key_value};
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (cnt_q != 3'd0) begin
                    // The counter is always reloaded by the strobe that made cnt non-zero.
                    if (idle_q == '0) begin
                        buf_d = '0;
                        cnt_d = '0;
                        tmo_d = 1'b1;
                    end else begin
                        idle_d = idle_q - TMO_W'(1);
                    end
                end
            end

            ACK: begin
                if (!kp.enable) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end else if (ack_cnt_q == '0) begin
                    state_d = GAP;
                    ack_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    ack_cnt_d = ack_cnt_q - ACK_W'(1);
                end
            end

            GAP: begin
                ack_d   = 1'b0;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = kp.enable ? COLLECT : IDLE;
            end

            default: begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                ack_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            idle_q    <= '0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            idle_q    <= idle_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign kp.code          = code_q;
    assign kp.code_ack      = ack_q;
    assign kp.digit_count   = cnt_q;
    assign kp.key_error     = err_q;
    assign kp.entry_timeout = tmo_q;

endmodule
